// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each grant runs one ACCESS cycle followed by one RESP cycle.
module dmem_arbiter #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [DATA_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef struct packed {
        logic              id;
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    localparam logic [DATA_W-1:0] LIMIT = DATA_W'(DEPTH);

    state_t            state, state_nxt;
    cmd_t              cmd, cmd_nxt;
    logic              ptr, ptr_nxt;
    logic              win;
    logic              oor;
    logic              acc;
    logic              rsp;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;

    assign oor = cmd.addr >= LIMIT;
    assign acc = state == ACCESS;
    assign rsp = state == RESP;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cmd       <= '0;
            ptr       <= 1'b0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            cmd   <= cmd_nxt;
            ptr   <= ptr_nxt;
            if (acc) begin
                resp_data <= (oor || cmd.we) ? '0 : mem_RD;
                resp_err  <= oor;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        ptr_nxt   = ptr;
        // ptr names the requester that wins a tie
        win       = (m0_req && m1_req) ? ptr : m1_req;
        unique case (state)
            IDLE, RESP: begin
                if (m0_req || m1_req) begin
                    state_nxt = ACCESS;
                    ptr_nxt   = ~win;
                    if (win)
                        cmd_nxt = '{id: 1'b1, we: m1_we,
                                    addr: m1_addr, wdata: m1_wdata};
                    else
                        cmd_nxt = '{id: 1'b0, we: m0_we,
                                    addr: m0_addr, wdata: m0_wdata};
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS:  state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_A    = cmd.addr;
    assign mem_WD   = cmd.wdata;
    assign mem_WE   = acc && cmd.we && !oor && rst;
    assign busy     = state != IDLE;

    assign m0_gnt   = acc && !cmd.id;
    assign m1_gnt   = acc && cmd.id;
    assign m0_done  = rsp && !cmd.id;
    assign m1_done  = rsp && cmd.id;
    assign m0_err   = m0_done && resp_err;
    assign m1_err   = m1_done && resp_err;
    assign m0_rdata = m0_done ? resp_data : '0;
    assign m1_rdata = m1_done ? resp_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model plus directed
// transactions with literal expectations.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic        mem_WE, busy;

    int checks = 0;
    int errors = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_done(m0_done),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
        .mem_RD(mem_RD), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pre(input int i);
        case (i)
            7:       return 32'h0000_0707;
            40:      return 32'h0000_0002;
            1023:    return 32'h0000_1234;
            default: return 32'h0000_1000 + i;
        endcase
    endfunction

    // Attached memory, written by the DUT
    logic [31:0] ram [0:1023];
    logic        ram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= pre(i);
            ram_loaded <= 1'b1;
        end else if (mem_WE && mem_A < 32'd1024) begin
            ram[mem_A[9:0]] <= mem_WD;
        end
    end

    assign mem_RD = (mem_A < 32'd1024) ? ram[mem_A[9:0]] : 32'hDEAD_BEEF;

    // Transaction-level model: one command in flight, age 1 = grant, 2 = done
    logic [31:0] shadow [0:1023];
    logic        m_loaded = 1'b0;
    logic        m_ok = 1'b0;
    int          m_age;
    logic        m_id, m_we, m_oor, m_last;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always @(posedge clk) begin : model
        logic w;
        if (!m_loaded) begin
            for (int i = 0; i < 1024; i++) shadow[i] <= pre(i);
            m_loaded <= 1'b1;
        end
        if (!rst) begin
            m_ok    <= 1'b1;
            m_age   <= 0;
            m_last  <= 1'b1;
            m_id    <= 1'b0;
            m_we    <= 1'b0;
            m_oor   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
        end else if (m_age == 1) begin
            m_rdata <= (m_we || m_oor) ? 32'h0 : shadow[m_addr[9:0]];
            if (m_we && !m_oor) shadow[m_addr[9:0]] <= m_wdata;
            m_age <= 2;
        end else if (m0_req || m1_req) begin
            w = (m0_req && m1_req) ? !m_last : m1_req;
            m_id    <= w;
            m_we    <= w ? m1_we : m0_we;
            m_addr  <= w ? m1_addr : m0_addr;
            m_wdata <= w ? m1_wdata : m0_wdata;
            m_oor   <= (w ? m1_addr : m0_addr) >= 32'd1024;
            m_last  <= w;
            m_age   <= 1;
        end else begin
            m_age <= 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            chk("busy", {31'd0, busy}, {31'd0, m_age != 0});
            chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, m_age == 1 && !m_id});
            chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, m_age == 1 && m_id});
            chk("m0_done", {31'd0, m0_done}, {31'd0, m_age == 2 && !m_id});
            chk("m1_done", {31'd0, m1_done}, {31'd0, m_age == 2 && m_id});
            chk("m0_err", {31'd0, m0_err},
                {31'd0, m_age == 2 && !m_id && m_oor});
            chk("m1_err", {31'd0, m1_err},
                {31'd0, m_age == 2 && m_id && m_oor});
            chk("mem_WE", {31'd0, mem_WE},
                {31'd0, m_age == 1 && m_we && !m_oor && rst});
            chk("mem_A", mem_A, m_addr);
            chk("mem_WD", mem_WD, m_wdata);
            if (m_age == 2 && !m_id) chk("m0_rdata", m0_rdata, m_rdata);
            if (m_age == 2 && m_id) chk("m1_rdata", m1_rdata, m_rdata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Entered and left 1 time unit after a rising edge
    task automatic txn(input logic id, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_we, input logic exp_err,
                       input logic [31:0] exp_rdata);
        if (id) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
        cyc();
        @(negedge clk);
        chk("t_gnt", {31'd0, id ? m1_gnt : m0_gnt}, 32'd1);
        chk("t_addr", mem_A, addr);
        chk("t_wd", mem_WD, wdata);
        chk("t_we", {31'd0, mem_WE}, {31'd0, exp_we});
        cyc();
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        chk("t_done", {31'd0, id ? m1_done : m0_done}, 32'd1);
        chk("t_err", {31'd0, id ? m1_err : m0_err}, {31'd0, exp_err});
        chk("t_rdata", id ? m1_rdata : m0_rdata, exp_rdata);
        cyc();
        chk("t_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_A", mem_A, 32'd0);
        chk("rst_mem_WD", mem_WD, 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        rst = 1'b1;
        cyc();
        cyc();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        txn(1'b0, 1'b1, 32'd28, 32'h20, 1'b1, 1'b0, 32'h0);
        txn(1'b1, 1'b0, 32'd40, 32'h0, 1'b0, 1'b0, 32'h2);
        txn(1'b1, 1'b1, 32'd5, 32'hCAFE, 1'b1, 1'b0, 32'h0);
        txn(1'b0, 1'b0, 32'd5, 32'h0, 1'b0, 1'b0, 32'hCAFE);
        txn(1'b0, 1'b1, 32'd1024, 32'h55, 1'b0, 1'b1, 32'h0);
        txn(1'b0, 1'b0, 32'd1023, 32'h0, 1'b0, 1'b0, 32'h1234);
        txn(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h0);
        txn(1'b0, 1'b0, 32'd28, 32'h0, 1'b0, 1'b0, 32'h20);

        // Reset lands on the grant cycle of a store
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd7; m0_wdata = 32'h77;
        cyc();
        rst = 1'b0;
        m0_req = 1'b0;
        @(negedge clk);
        chk("abort_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("abort_we", {31'd0, mem_WE}, 32'd0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, m0_done}, 32'd0);
        cyc();
        txn(1'b0, 1'b0, 32'd7, 32'h0, 1'b0, 1'b0, 32'h0707);

        // Continuous contention straight out of reset
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd200;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            @(negedge clk);
            chk("rr_g0", {31'd0, m0_gnt}, {31'd0, k % 4 == 1});
            chk("rr_g1", {31'd0, m1_gnt}, {31'd0, k % 4 == 3});
            chk("rr_d0", {31'd0, m0_done}, {31'd0, k % 4 == 2});
            chk("rr_d1", {31'd0, m1_done}, {31'd0, k % 4 == 0});
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        cyc();
        cyc();
        chk("end_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DEPTH, default 1024, number of 32-bit words in the attached data memory; valid word indices are 0..DEPTH-1.
REQ-002 Parameter: DATA_W, default 32, data and address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low, sampled on the rising edge of clk.
REQ-005 m0_req  input  1  requester 0 (core load/store) access request; level, held until m0_gnt.
REQ-006 m0_we  input  1  requester 0 write enable (1 = store, 0 = load).
REQ-007 m0_addr  input  32  requester 0 word index.
REQ-008 m0_wdata  input  32  requester 0 store data.
REQ-009 m0_gnt  output  1  requester 0 grant; one-cycle pulse.
REQ-010 m0_done  output  1  requester 0 completion; one-cycle pulse.
REQ-011 m0_rdata  output  32  requester 0 load data; valid while m0_done=1.
REQ-012 m0_err  output  1  requester 0 out-of-range flag; valid while m0_done=1.
REQ-013 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_rdata, m1_err  same directions, widths and meaning for requester 1 (debug/loader port).
REQ-014 mem_A  output  32  address to data memory.
REQ-015 mem_WD  output  32  write data to data memory.
REQ-016 mem_WE  output  1  write enable to data memory.
REQ-017 mem_RD  input  32  combinational read data from data memory.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-020 Arbitration: evaluated in IDLE and RESP on the current req inputs. If any req=1, latch the winner's id, we, addr and wdata into command registers and go to ACCESS; otherwise go to IDLE.
REQ-021 Round-robin: a single priority pointer SHALL select the winner when both req=1. The pointer moves to the non-winner after each grant. A lone requester always wins.
REQ-022 ACCESS: mem_A = cmd_addr and mem_WD = cmd_wdata. mem_WE = cmd_we AND in-range AND rst. The winner's gnt = 1. Next state is RESP.
REQ-023 Outside ACCESS: mem_WE = 0, and mem_A and mem_WD hold their last values.
REQ-024 At the rising edge that ends ACCESS, mem_RD SHALL be captured into the response register. It is captured as 0 if the transaction is out-of-range or a store.
REQ-025 RESP: the winner's done = 1, rdata = captured value, err = out-of-range flag. All other gnt, done and err outputs are 0.
REQ-026 Latency: request seen in IDLE at cycle N -> gnt in N+1 -> done in N+2. Back-to-back grants via RESP give one transaction every 2 cycles.
REQ-027 Requester rule: drop req (or present a new request) on the edge after observing gnt. A req still high in RESP is a new request.
REQ-028 Out-of-range: cmd_addr >= DEPTH SHALL suppress mem_WE, return rdata = 0 and set err = 1. Out-of-range requests still complete with done.
REQ-029 The non-winning requester SHALL be unaffected and be granted no later than the next arbitration point.
REQ-030 Only one of m0_gnt and m1_gnt is ever high, and only one of m0_done and m1_done is ever high.

Reset
REQ-031 While rst=0 at a rising edge, the next state SHALL be: IDLE, pointer favoring m0, command and response registers 0, and all gnt, done, err, rdata, busy, mem_A and mem_WD outputs 0.
REQ-032 mem_WE SHALL be combinationally 0 during any cycle with rst=0, including a reset asserted mid-ACCESS.
REQ-033 A reset mid-transaction SHALL abort it with no done pulse; requesters re-request after reset.

Verification
REQ-034 Reset then idle: rst=0 for 2 cycles, then rst=1, no req -> busy=0, all outputs 0, mem_WE never 1.
REQ-035 m0 store: m0_req=1, we=1, addr=28, wdata=0x20 -> m0_gnt at N+1 with mem_A=28, mem_WD=0x20, mem_WE=1; m0_done at N+2 with err=0.
REQ-036 m1 load: mem_RD returns 0x2 for addr 40; m1_req=1, we=0, addr=40 -> m1_done at N+2, m1_rdata=0x2, mem_WE stays 0.
REQ-037 Contention: m0 and m1 request simultaneously and continuously after reset -> grants alternate m0, m1, m0, ..., one grant every 2 cycles, never both.
REQ-038 Out-of-range: m0 store to addr=1024 -> mem_WE=0 throughout; m0_done with m0_err=1 and m0_rdata=0.
REQ-039 Reset mid-ACCESS: rst=0 in the cycle m0_gnt=1 on a store -> mem_WE=0 that cycle, no m0_done, and state IDLE after the edge.
